register_bank_writer: RTL and testbench
=======================================

REGISTER_BANK_WRITER -- requirements
Module: register_bank_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and of the write data.
REQ-002 Parameter COUNT_WIDTH, default 16, width of Write_Count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Write_Enable  input  1  write request qualifier, sampled each rising edge.
REQ-006 Write_Register  input  5  destination register index 0..31.
REQ-007 Write_Data  input  DATA_WIDTH  value to write.
REQ-008 Q_0 .. Q_31  output  DATA_WIDTH each  current content of registers 0..31; feeds the 32:1 read multiplexers.
REQ-009 Pending_Valid  output  1  staging register holds an uncommitted write.
REQ-010 Pending_Register  output  5  index of the staged write.
REQ-011 Pending_Data  output  DATA_WIDTH  data of the staged write, for read-side forwarding.
REQ-012 Write_Count  output  COUNT_WIDTH  number of committed writes since reset.

Function
REQ-013 Two-stage write path: stage 1 (staging) captures the request; stage 2 (commit) decodes the index 5-to-32 and updates exactly one register.
REQ-014 Rising edge N with Write_Enable=1: Pending_Valid<=1, Pending_Register<=Write_Register, Pending_Data<=Write_Data.
REQ-015 Rising edge N with Write_Enable=0: Pending_Valid<=0; Pending_Register and Pending_Data hold.
REQ-016 Rising edge N+1 with Pending_Valid=1: Q_[Pending_Register]<=Pending_Data; all other Q_x hold; write visible on Q_x after the second edge (latency 2 cycles).
REQ-017 Back-to-back writes, one per cycle, accepted without stall; no ready/back-pressure signal exists.
REQ-018 Consecutive writes to the same index commit in order; the later value is final.
REQ-019 Decode one-hot: never more than one register updated per edge.
REQ-020 Write_Count increments by 1 on every edge where a commit occurs (including a commit discarded by REQ-025); wraps from 2^COUNT_WIDTH-1 to 0.
REQ-021 Write_Enable with Write_Register X and/or undefined data is not required to be handled; all 32 indices are legal.

Reset
REQ-022 reset low asynchronously forces all Q_0..Q_31 to 0, Pending_Valid to 0, Pending_Register to 0, Pending_Data to 0, Write_Count to 0.
REQ-023 A staged write present when reset asserts is discarded and never committed.
REQ-024 First request is captured on the first rising edge with reset high.

Configuration
REQ-025 Macro ZERO_REGISTER_PROTECT_EN defined: commits to index 0 are discarded, Q_0 is constantly 0; Pending_* still reflect the staged request.
REQ-026 Macro ZERO_REGISTER_PROTECT_EN undefined: register 0 is an ordinary writable register.

Verification
REQ-027 reset low, then Write_Enable=1, Write_Register=5, Write_Data=0xDEADBEEF -> after edge 1 Pending_Valid=1, Pending_Register=5, Pending_Data=0xDEADBEEF; after edge 2 Q_5=0xDEADBEEF, all other Q_x=0, Write_Count=1.
REQ-028 Writes 1->0x11, 2->0x22, 3->0x33 on consecutive edges -> Q_1, Q_2, Q_3 update on edges 2, 3, 4 respectively; Write_Count=3.
REQ-029 Writes 7->0xA then 7->0xB on consecutive edges -> Q_7=0xA after edge 2, 0xB after edge 3.
REQ-030 Write 0->0xFFFFFFFF -> Q_0=0 with ZERO_REGISTER_PROTECT_EN, 0xFFFFFFFF without; Write_Count=1 in both.
REQ-031 Write 9->0x55 staged, reset pulsed low between edges 1 and 2 -> Q_9=0, Pending_Valid=0, Write_Count=0 immediately and after next edges.
REQ-032 COUNT_WIDTH=4, 17 consecutive writes -> Write_Count=1 after wrap.

Source files
------------

// File: rtl/register_bank_writer_if.sv
// Write-side bus of the register bank: request, staged-write visibility and commit count.
interface register_bank_writer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   Write_Enable;
    logic [4:0]             Write_Register;
    logic [DATA_WIDTH-1:0]  Write_Data;
    logic                   Pending_Valid;
    logic [4:0]             Pending_Register;
    logic [DATA_WIDTH-1:0]  Pending_Data;
    logic [COUNT_WIDTH-1:0] Write_Count;

    modport master (
        output Write_Enable, Write_Register, Write_Data,
        input  Pending_Valid, Pending_Register, Pending_Data, Write_Count
    );

    modport slave (
        input  Write_Enable, Write_Register, Write_Data,
        output Pending_Valid, Pending_Register, Pending_Data, Write_Count
    );
endinterface

// File: rtl/register_bank_writer.sv
// 32-entry register bank with a staged two-cycle write path and commit counter.
// Define ZERO_REGISTER_PROTECT_EN to make register 0 read-only zero.
module register_bank_writer #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    register_bank_writer_if.slave bus,
    output logic [DATA_WIDTH-1:0] Q_0,
    output logic [DATA_WIDTH-1:0] Q_1,
    output logic [DATA_WIDTH-1:0] Q_2,
    output logic [DATA_WIDTH-1:0] Q_3,
    output logic [DATA_WIDTH-1:0] Q_4,
    output logic [DATA_WIDTH-1:0] Q_5,
    output logic [DATA_WIDTH-1:0] Q_6,
    output logic [DATA_WIDTH-1:0] Q_7,
    output logic [DATA_WIDTH-1:0] Q_8,
    output logic [DATA_WIDTH-1:0] Q_9,
    output logic [DATA_WIDTH-1:0] Q_10,
    output logic [DATA_WIDTH-1:0] Q_11,
    output logic [DATA_WIDTH-1:0] Q_12,
    output logic [DATA_WIDTH-1:0] Q_13,
    output logic [DATA_WIDTH-1:0] Q_14,
    output logic [DATA_WIDTH-1:0] Q_15,
    output logic [DATA_WIDTH-1:0] Q_16,
    output logic [DATA_WIDTH-1:0] Q_17,
    output logic [DATA_WIDTH-1:0] Q_18,
    output logic [DATA_WIDTH-1:0] Q_19,
    output logic [DATA_WIDTH-1:0] Q_20,
    output logic [DATA_WIDTH-1:0] Q_21,
    output logic [DATA_WIDTH-1:0] Q_22,
    output logic [DATA_WIDTH-1:0] Q_23,
    output logic [DATA_WIDTH-1:0] Q_24,
    output logic [DATA_WIDTH-1:0] Q_25,
    output logic [DATA_WIDTH-1:0] Q_26,
    output logic [DATA_WIDTH-1:0] Q_27,
    output logic [DATA_WIDTH-1:0] Q_28,
    output logic [DATA_WIDTH-1:0] Q_29,
    output logic [DATA_WIDTH-1:0] Q_30,
    output logic [DATA_WIDTH-1:0] Q_31
);
    logic                   pend_valid;
    logic [4:0]             pend_reg;
    logic [DATA_WIDTH-1:0]  pend_data;
    logic [COUNT_WIDTH-1:0] write_count;
    logic [31:0]            commit_sel;
    logic [DATA_WIDTH-1:0]  bank [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_reg   <= '0;
            pend_data  <= '0;
        end else if (bus.Write_Enable) begin
            pend_valid <= 1'b1;
            pend_reg   <= bus.Write_Register;
            pend_data  <= bus.Write_Data;
        end else begin
            pend_valid <= 1'b0;
        end
    end

    // One-hot commit select; index 0 is masked out when the zero register is protected.
    always_comb begin
        commit_sel = '0;
        if (pend_valid) begin
            commit_sel[pend_reg] = 1'b1;
        end
`ifdef ZERO_REGISTER_PROTECT_EN
        commit_sel[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (commit_sel[i]) begin
                    bank[i] <= pend_data;
                end
            end
        end
    end

    // Discarded zero-register commits still count as commits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_count <= '0;
        end else if (pend_valid) begin
            write_count <= write_count + COUNT_WIDTH'(1);
        end
    end

    assign bus.Pending_Valid    = pend_valid;
    assign bus.Pending_Register = pend_reg;
    assign bus.Pending_Data     = pend_data;
    assign bus.Write_Count      = write_count;

    assign Q_0  = bank[0];
    assign Q_1  = bank[1];
    assign Q_2  = bank[2];
    assign Q_3  = bank[3];
    assign Q_4  = bank[4];
    assign Q_5  = bank[5];
    assign Q_6  = bank[6];
    assign Q_7  = bank[7];
    assign Q_8  = bank[8];
    assign Q_9  = bank[9];
    assign Q_10 = bank[10];
    assign Q_11 = bank[11];
    assign Q_12 = bank[12];
    assign Q_13 = bank[13];
    assign Q_14 = bank[14];
    assign Q_15 = bank[15];
    assign Q_16 = bank[16];
    assign Q_17 = bank[17];
    assign Q_18 = bank[18];
    assign Q_19 = bank[19];
    assign Q_20 = bank[20];
    assign Q_21 = bank[21];
    assign Q_22 = bank[22];
    assign Q_23 = bank[23];
    assign Q_24 = bank[24];
    assign Q_25 = bank[25];
    assign Q_26 = bank[26];
    assign Q_27 = bank[27];
    assign Q_28 = bank[28];
    assign Q_29 = bank[29];
    assign Q_30 = bank[30];
    assign Q_31 = bank[31];
endmodule

// File: tb/tb_register_bank_writer.sv
// Scoreboard bench for register_bank_writer: per-cycle request queue, array model of the bank.
module tb_register_bank_writer;
    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct {
        bit          en;
        logic [4:0]  r;
        logic [DW-1:0] d;
    } req_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] q [32];

    register_bank_writer_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) wbus ();

    register_bank_writer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .bus(wbus.slave),
        .Q_0(q[0]),   .Q_1(q[1]),   .Q_2(q[2]),   .Q_3(q[3]),
        .Q_4(q[4]),   .Q_5(q[5]),   .Q_6(q[6]),   .Q_7(q[7]),
        .Q_8(q[8]),   .Q_9(q[9]),   .Q_10(q[10]), .Q_11(q[11]),
        .Q_12(q[12]), .Q_13(q[13]), .Q_14(q[14]), .Q_15(q[15]),
        .Q_16(q[16]), .Q_17(q[17]), .Q_18(q[18]), .Q_19(q[19]),
        .Q_20(q[20]), .Q_21(q[21]), .Q_22(q[22]), .Q_23(q[23]),
        .Q_24(q[24]), .Q_25(q[25]), .Q_26(q[26]), .Q_27(q[27]),
        .Q_28(q[28]), .Q_29(q[29]), .Q_30(q[30]), .Q_31(q[31])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ZERO_REGISTER_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    req_t exp_q [$];

    // Reference state: what the bank should hold, the staged request, and the commit tally.
    logic [DW-1:0] model [32];
    bit            stg_v;
    logic [4:0]    stg_r;
    logic [DW-1:0] stg_d;
    logic [4:0]    last_r;
    logic [DW-1:0] last_d;
    int            model_cnt;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = '0;
        stg_v = 1'b0; stg_r = '0; stg_d = '0;
        last_r = '0; last_d = '0;
        model_cnt = 0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_bank(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < 32; i++) begin
            if (q[i] !== model[i] && bad < 0) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s Q_%0d actual=0x%0h required=0x%0h t=%0t", name, bad, q[bad], model[bad], $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 32; i++) model[i] = '0;
        check_bank({name, "_bank"});
        check({name, "_pvalid"}, 64'(wbus.Pending_Valid), 64'd0);
        check({name, "_preg"}, 64'(wbus.Pending_Register), 64'd0);
        check({name, "_pdata"}, 64'(wbus.Pending_Data), 64'd0);
        check({name, "_count"}, 64'(wbus.Write_Count), 64'd0);
    endtask

    // Drive one cycle of stimulus at the falling edge and record what it asks for.
    task automatic cyc(input bit en, input logic [4:0] r, input logic [DW-1:0] d);
        req_t e;
        wbus.Write_Enable   = en;
        wbus.Write_Register = r;
        wbus.Write_Data     = d;
        e.en = en; e.r = r; e.d = d;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic pulse_reset(input string name);
        mon_en = 1'b0;
        wbus.Write_Enable = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero(name);
        #1;
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    // Monitor: after each rising edge, retire the previously staged request and compare.
    always begin
        req_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_underflow actual=empty required=entry t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (stg_v) begin
                    if (!(PROTECT && stg_r == 5'd0)) model[stg_r] = stg_d;
                    model_cnt = (model_cnt + 1) % (1 << CW);
                end
                check_bank("bank");
                check("write_count", 64'(wbus.Write_Count), 64'(model_cnt));
                if (e.en) begin
                    last_r = e.r;
                    last_d = e.d;
                end
                check("pending_valid", 64'(wbus.Pending_Valid), 64'(e.en));
                check("pending_register", 64'(wbus.Pending_Register), 64'(last_r));
                check("pending_data", 64'(wbus.Pending_Data), 64'(last_d));
                stg_v = e.en; stg_r = e.r; stg_d = e.d;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] r;
        reset = 1'b0;
        wbus.Write_Enable = 1'b0;
        wbus.Write_Register = '0;
        wbus.Write_Data = '0;
        model_reset();
        #2;
        check_all_zero("reset_state");
        #1;
        reset = 1'b1;
        mon_en = 1'b1;

        // Single write, then idle to see the commit land.
        cyc(1'b1, 5'd5, 32'hDEADBEEF);
        cyc(1'b0, 5'd0, 32'h0);
        cyc(1'b0, 5'd0, 32'h0);
        check("single_q5", 64'(q[5]), 64'hDEADBEEF);

        pulse_reset("reset_b2b");
        cyc(1'b1, 5'd1, 32'h11);
        cyc(1'b1, 5'd2, 32'h22);
        cyc(1'b1, 5'd3, 32'h33);
        cyc(1'b0, 5'd0, 32'h0);
        cyc(1'b0, 5'd0, 32'h0);
        check("b2b_count", 64'(wbus.Write_Count), 64'd3);

        cyc(1'b1, 5'd7, 32'hA);
        cyc(1'b1, 5'd7, 32'hB);
        cyc(1'b0, 5'd0, 32'h0);
        cyc(1'b0, 5'd0, 32'h0);
        check("same_idx_q7", 64'(q[7]), 64'hB);

        pulse_reset("reset_zero");
        cyc(1'b1, 5'd0, 32'hFFFFFFFF);
        cyc(1'b0, 5'd0, 32'h0);
        cyc(1'b0, 5'd0, 32'h0);
        check("zero_q0", 64'(q[0]), PROTECT ? 64'd0 : 64'hFFFFFFFF);
        check("zero_count", 64'(wbus.Write_Count), 64'd1);

        // Staged write dropped by a reset pulse between its two edges.
        pulse_reset("reset_pre");
        cyc(1'b1, 5'd9, 32'h55);
        pulse_reset("reset_mid");
        cyc(1'b0, 5'd0, 32'h0);
        cyc(1'b0, 5'd0, 32'h0);
        check("drop_q9", 64'(q[9]), 64'd0);
        check("drop_count", 64'(wbus.Write_Count), 64'd0);

        // Counter wrap at COUNT_WIDTH=4.
        for (int i = 0; i < 17; i++) cyc(1'b1, 5'(i), 32'(i + 100));
        cyc(1'b0, 5'd0, 32'h0);
        cyc(1'b0, 5'd0, 32'h0);
        check("wrap_count", 64'(wbus.Write_Count), 64'd1);

        // Random traffic, partly concentrated on a few indices to provoke same-index overwrites.
        pulse_reset("reset_rand");
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            cyc($urandom_range(0, 3) != 0, r, $urandom);
        end
        cyc(1'b0, 5'd0, 32'h0);
        cyc(1'b0, 5'd0, 32'h0);
        mon_en = 1'b0;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
